dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 clock  in  1  master clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-003 cpu_req  in  1  processor M-stage requests a dmem access this cycle.
REQ-004 cpu_wren  in  1  processor access is a write (1) or read (0).
REQ-005 cpu_addr  in  32  processor word address.
REQ-006 cpu_wdata  in  32  processor write data.
REQ-007 cpu_stall  out  1  processor must hold its M stage; request not granted this cycle.
REQ-008 cpu_rdata  out  32  read data returned to processor.
REQ-009 per_req  in  1  peripheral request; held high until per_ack.
REQ-010 per_wren  in  1  peripheral access is a write (1) or read (0).
REQ-011 per_addr  in  32  peripheral word address.
REQ-012 per_wdata  in  32  peripheral write data.
REQ-013 per_ack  out  1  one-cycle pulse: peripheral request granted this cycle.
REQ-014 per_rvalid  out  1  one-cycle pulse: per_rdata valid.
REQ-015 per_rdata  out  32  read data returned to peripheral.
REQ-016 mem_addr  out  32  dmem address.
REQ-017 mem_wdata  out  32  dmem write data.
REQ-018 mem_wren  out  1  dmem write enable.
REQ-019 mem_q  in  32  dmem read data, valid one cycle after address is presented.

Function
REQ-020 Each cycle, the block SHALL grant at most one requester; the granted requester's addr/wdata/wren SHALL drive mem_* combinationally in that cycle.
REQ-021 With no grant, mem_wren SHALL be 0; mem_addr and mem_wdata SHALL be 0.
REQ-022 Only one requester active: that requester SHALL be granted.
REQ-023 Both requesting: CPU SHALL win unless starve_cnt equals 3, in which case the peripheral SHALL win.
REQ-024 starve_cnt (2-bit) SHALL increment on each cycle CPU wins while per_req is high, SHALL clear when the peripheral is granted or per_req is low, and SHALL saturate at 3.
REQ-025 cpu_stall SHALL equal cpu_req AND NOT cpu_granted, combinationally.
REQ-026 per_ack SHALL be high exactly in cycles in which the peripheral is granted.
REQ-027 A return-owner register SHALL record {valid, owner} for each granted read; writes SHALL not set valid.
REQ-028 Cycle after a granted peripheral read: per_rvalid SHALL be 1 and per_rdata SHALL equal mem_q; otherwise per_rvalid SHALL be 0 and per_rdata SHALL be 0.
REQ-029 Cycle after a granted CPU read: cpu_rdata SHALL equal mem_q; otherwise cpu_rdata SHALL be 0.
REQ-030 Back-to-back reads by alternating owners SHALL each route data to the correct owner with no bubble.
REQ-031 Peripheral request changes while per_req is high and not yet acked SHALL take effect at the next arbitration; the block SHALL NOT latch request fields.
REQ-032 Total latency: grant same cycle as request when uncontested; read data one cycle after grant.

Reset
REQ-033 While reset is low at a rising edge: starve_cnt SHALL clear to 0 and return-owner valid SHALL clear to 0.
REQ-034 Reset-state outputs: per_rvalid=0, per_rdata=0, cpu_rdata=0; grant outputs remain combinational functions of inputs, with starve_cnt=0.
REQ-035 A read granted in the cycle reset is asserted SHALL NOT produce per_rvalid or cpu_rdata afterward.

Verification
REQ-036 CPU-only read addr 0x10, mem returns 0xDEADBEEF -> cpu_stall=0, mem_addr=0x10 in cycle 0; cpu_rdata=0xDEADBEEF in cycle 1; per_rvalid stays 0.
REQ-037 Peripheral-only write addr 0x20 data 0x5 -> per_ack=1, mem_wren=1, mem_addr=0x20, mem_wdata=0x5 same cycle; no per_rvalid.
REQ-038 Both request continuously -> CPU wins cycles 0-2 (cpu_stall=0, per_ack=0), cycle 3 per_ack=1 and cpu_stall=1, starve_cnt back to 0, pattern repeats every 4 cycles.
REQ-039 Alternating reads CPU addr 0x1 then peripheral addr 0x2, mem_q returns 0xA then 0xB -> cpu_rdata=0xA cycle 1; per_rvalid=1, per_rdata=0xB cycle 2.
REQ-040 Peripheral read granted, reset low on next edge -> per_rvalid=0 after that edge; starve_cnt=0.
REQ-041 starve_cnt at 2, per_req drops for one cycle -> starve_cnt=0; CPU wins next 3 contested cycles before peripheral.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter that shares one dmem port between the CPU M stage and a peripheral master.
// The CPU normally has priority; a starvation counter hands every fourth contested cycle to the peripheral.
module dmem_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_wren,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic [31:0] cpu_rdata,
   input  logic        per_req,
   input  logic        per_wren,
   input  logic [31:0] per_addr,
   input  logic [31:0] per_wdata,
   output logic        per_ack,
   output logic        per_rvalid,
   output logic [31:0] per_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wren,
   input  logic [31:0] mem_q
);

   logic [1:0] starve_cnt;
   logic       cpu_granted;
   logic       per_granted;
   logic       ret_valid;
   logic       ret_owner_per;

   // The peripheral wins when it is alone or when it has lost three contested cycles in a row.
   always_comb begin
      per_granted = per_req && (!cpu_req || (starve_cnt == 2'd3));
      cpu_granted = cpu_req && !per_granted;
   end

   assign cpu_stall = cpu_req && !cpu_granted;
   assign per_ack   = per_granted;

   always_comb begin
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_wren  = 1'b0;
      if (cpu_granted) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_wren  = cpu_wren;
      end else if (per_granted) begin
         mem_addr  = per_addr;
         mem_wdata = per_wdata;
         mem_wren  = per_wren;
      end
   end

   // Return-owner tracking: dmem answers one cycle later, so remember who issued the read.
   always_ff @(posedge clock) begin
      if (!reset) begin
         starve_cnt    <= 2'd0;
         ret_valid     <= 1'b0;
         ret_owner_per <= 1'b0;
      end else begin
         if (per_granted || !per_req) begin
            starve_cnt <= 2'd0;
         end else if (cpu_granted && (starve_cnt != 2'd3)) begin
            starve_cnt <= starve_cnt + 2'd1;
         end
         ret_valid     <= (cpu_granted && !cpu_wren) || (per_granted && !per_wren);
         ret_owner_per <= per_granted;
      end
   end

   assign per_rvalid = ret_valid && ret_owner_per;
   assign per_rdata  = per_rvalid ? mem_q : 32'd0;
   assign cpu_rdata  = (ret_valid && !ret_owner_per) ? mem_q : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant/mux checks plus a scoreboard of expected read returns.
module tb_dmem_arbiter;

   logic        clock;
   logic        reset;
   logic        cpu_req;
   logic        cpu_wren;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic        per_req;
   logic        per_wren;
   logic [31:0] per_addr;
   logic [31:0] per_wdata;
   logic        per_ack;
   logic        per_rvalid;
   logic [31:0] per_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wren;
   logic [31:0] mem_q;

   typedef struct {
      logic        is_per;
      logic [31:0] data;
   } ret_t;

   ret_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam int GNONE = 0;
   localparam int GCPU  = 1;
   localparam int GPER  = 2;

   dmem_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_wren   (cpu_wren),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_stall  (cpu_stall),
      .cpu_rdata  (cpu_rdata),
      .per_req    (per_req),
      .per_wren   (per_wren),
      .per_addr   (per_addr),
      .per_wdata  (per_wdata),
      .per_ack    (per_ack),
      .per_rvalid (per_rvalid),
      .per_rdata  (per_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wren   (mem_wren),
      .mem_q      (mem_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Fixed read contents of the emulated dmem, keyed by word address.
   function automatic logic [31:0] ramModel(input logic [31:0] a);
      case (a)
         32'h10:  ramModel = 32'hDEADBEEF;
         32'h1:   ramModel = 32'hA;
         32'h2:   ramModel = 32'hB;
         default: ramModel = a ^ 32'h5A5A_0000;
      endcase
   endfunction

   always @(posedge clock) mem_q <= ramModel(mem_addr);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Read data appearing this cycle must match the oldest queued expectation, or be idle zeros.
   task automatic checkReturns(input string tag);
      ret_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_per) begin
            checkOutput({tag, ".per_rvalid"}, {31'd0, per_rvalid}, 32'd1);
            checkOutput({tag, ".per_rdata"}, per_rdata, e.data);
            checkOutput({tag, ".cpu_rdata"}, cpu_rdata, 32'd0);
         end else begin
            checkOutput({tag, ".cpu_rdata"}, cpu_rdata, e.data);
            checkOutput({tag, ".per_rvalid"}, {31'd0, per_rvalid}, 32'd0);
            checkOutput({tag, ".per_rdata"}, per_rdata, 32'd0);
         end
      end else begin
         checkOutput({tag, ".per_rvalid"}, {31'd0, per_rvalid}, 32'd0);
         checkOutput({tag, ".per_rdata"}, per_rdata, 32'd0);
         checkOutput({tag, ".cpu_rdata"}, cpu_rdata, 32'd0);
      end
   endtask

   // One clock cycle: check returns from the last cycle, drive this cycle, check grant and mux, advance.
   task automatic applyStimulus(input string tag, input logic rst,
                                input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                                input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pwd,
                                input int grant);
      logic [31:0] ea;
      logic [31:0] ed;
      logic        ew;
      ret_t        r;
      checkReturns(tag);
      reset     = rst;
      cpu_req   = cr;
      cpu_wren  = cw;
      cpu_addr  = ca;
      cpu_wdata = cwd;
      per_req   = pr;
      per_wren  = pw;
      per_addr  = pa;
      per_wdata = pwd;
      #2;
      ea = 32'd0;
      ed = 32'd0;
      ew = 1'b0;
      if (grant == GCPU) begin
         ea = ca; ed = cwd; ew = cw;
      end else if (grant == GPER) begin
         ea = pa; ed = pwd; ew = pw;
      end
      checkOutput({tag, ".cpu_stall"}, {31'd0, cpu_stall}, {31'd0, cr && (grant != GCPU)});
      checkOutput({tag, ".per_ack"}, {31'd0, per_ack}, {31'd0, grant == GPER});
      checkOutput({tag, ".mem_addr"}, mem_addr, ea);
      checkOutput({tag, ".mem_wdata"}, mem_wdata, ed);
      checkOutput({tag, ".mem_wren"}, {31'd0, mem_wren}, {31'd0, ew});
      if (rst && (grant != GNONE) && !ew) begin
         r.is_per = (grant == GPER);
         r.data   = ramModel(ea);
         sb.push_back(r);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input string tag);
      applyStimulus(tag, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, GNONE);
   endtask

   initial begin
      reset     = 1'b0;
      cpu_req   = 1'b0;
      cpu_wren  = 1'b0;
      cpu_addr  = 32'd0;
      cpu_wdata = 32'd0;
      per_req   = 1'b0;
      per_wren  = 1'b0;
      per_addr  = 32'd0;
      per_wdata = 32'd0;
      @(posedge clock);
      #1;
      applyStimulus("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, GNONE);

      applyStimulus("cpu_rd", 1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, GCPU);
      applyStimulus("per_wr", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h20, 32'h5, GPER);
      idle("idle0");

      // Continuous contention: CPU wins three, peripheral gets the fourth; peripheral fields change while waiting.
      for (int i = 0; i < 8; i++) begin
         applyStimulus($sformatf("contend%0d", i), 1'b1, 1'b1, 1'b0, 32'h30 + i, 32'd0,
                       1'b1, 1'b0, 32'h40 + i, 32'd0, ((i % 4) == 3) ? GPER : GCPU);
      end
      idle("idle1");

      applyStimulus("alt_cpu", 1'b1, 1'b1, 1'b0, 32'h1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, GCPU);
      applyStimulus("alt_per", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h2, 32'd0, GPER);
      idle("idle2");

      // Counter reaches 2, peripheral drops for a cycle, then it must lose three more contested cycles.
      applyStimulus("drop_a", 1'b1, 1'b1, 1'b1, 32'h50, 32'h111, 1'b1, 1'b0, 32'h60, 32'd0, GCPU);
      applyStimulus("drop_b", 1'b1, 1'b1, 1'b1, 32'h51, 32'h222, 1'b1, 1'b0, 32'h61, 32'd0, GCPU);
      applyStimulus("drop_gap", 1'b1, 1'b1, 1'b0, 32'h52, 32'd0, 1'b0, 1'b0, 32'h62, 32'd0, GCPU);
      for (int i = 0; i < 4; i++) begin
         applyStimulus($sformatf("after_drop%0d", i), 1'b1, 1'b1, 1'b1, 32'h70 + i, 32'h300 + i,
                       1'b1, 1'b0, 32'h80 + i, 32'd0, (i == 3) ? GPER : GCPU);
      end
      idle("idle3");

      applyStimulus("rst_per_rd", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h44, 32'd0, GPER);
      idle("after_rst_per");

      applyStimulus("pre_rst_a", 1'b1, 1'b1, 1'b0, 32'h90, 32'd0, 1'b1, 1'b1, 32'hA0, 32'h77, GCPU);
      applyStimulus("pre_rst_b", 1'b1, 1'b1, 1'b0, 32'h91, 32'd0, 1'b1, 1'b1, 32'hA1, 32'h78, GCPU);
      applyStimulus("rst_cpu_rd", 1'b0, 1'b1, 1'b0, 32'h92, 32'd0, 1'b1, 1'b1, 32'hA2, 32'h79, GCPU);
      for (int i = 0; i < 4; i++) begin
         applyStimulus($sformatf("post_rst%0d", i), 1'b1, 1'b1, 1'b0, 32'hB0 + i, 32'd0,
                       1'b1, 1'b1, 32'hC0 + i, 32'h900 + i, (i == 3) ? GPER : GCPU);
      end
      idle("drain0");
      idle("drain1");

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("[TB] FAIL scoreboard_empty: observed %0d expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
